alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational alu instance between two requesters (port 0, port 1).
//  Round-robin arbitration, valid/ready handshake on requests.
//  One response channel tagged with requester id. One op in flight at a time.
//  Sits in front of the alu: owns its a/b/command inputs, registers its result.
// PARAMETERS
//  A_W    4  width of operand a (alu a input)
//  B_W    5  width of operand b and of result (alu b/sum)
//  CMD_W  3  width of alu command
//  CNT_W  8  width of completed-operation counter
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      reset, asynchronous, active-high
//  req0_valid  in   1      requester 0 has an operation
//  req0_ready  out  1      requester 0 operation accepted this cycle (valid&&ready)
//  req0_a      in   A_W    requester 0 operand a
//  req0_b      in   B_W    requester 0 operand b
//  req0_cmd    in   CMD_W  requester 0 alu command
//  req1_*      --   --     identical set for requester 1
//  alu_a       out  A_W    to alu a
//  alu_b       out  B_W    to alu b
//  alu_cmd     out  CMD_W  to alu command; 0 except in EXEC
//  alu_res     in   B_W    from alu sum (combinational)
//  rsp_valid   out  1      result available
//  rsp_id      out  1      requester that issued the result
//  rsp_res     out  B_W    registered alu result
//  rsp_ready   in   1      consumer takes result
//  busy        out  1      state != IDLE
//  op_count    out  CNT_W  completed ops (response handshakes), wraps
// BEHAVIOUR
//  - Reset: state IDLE, prio=0, latched a/b/cmd/id=0, all outputs 0, op_count=0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE. EXEC lasts exactly 1 cycle.
//  - IDLE: reqN_ready=1 iff reqN_valid and (other not valid or prio==N).
//    At most one ready per cycle. Ready is 0 in EXEC/RESP.
//  - Accept (valid&&ready, IDLE): latch a,b,cmd,id; prio <= other id; -> EXEC.
//  - EXEC: alu_cmd=latched cmd. rsp_res <= alu_res at end of cycle. -> RESP.
//  - Outside EXEC: alu_cmd=0. alu_a/alu_b always show latched operands.
//  - RESP: rsp_valid=1; rsp_id/rsp_res stable until rsp_ready.
//    rsp_valid&&rsp_ready: op_count+1 (mod 2^CNT_W), -> IDLE.
//  - Latency: accept at cycle N -> EXEC N+1 -> rsp_valid from N+2.
//    Best case one op per 3 cycles; no request accepted while RESP pending.
//  - cmd 0 is forwarded unchanged; no command is decoded or rejected here.
//  - Valid dropped before handshake: no effect, prio unchanged.
//  - Reset mid-EXEC or mid-RESP: op discarded, no response, prio=0.
//  - No width conversion: operands and result pass bit-exact.
// TESTING
//  1. req0 a=10 b=1 cmd=001, rsp_ready=1 -> alu_cmd=001 for exactly 1 cycle;
//     rsp_valid 2 cycles after accept; rsp_id=0; rsp_res=alu_res in EXEC; op_count=1.
//  2. Both valid continuously, 4 ops, after reset -> rsp_id sequence 0,1,0,1.
//  3. req1 a=11 b=21 cmd=011, rsp_ready=0 for 5 cycles -> rsp_valid, rsp_res stable;
//     req0/req1_ready=0; op_count unchanged until ready rises.
//  4. rst asserted in EXEC -> outputs 0 immediately; no rsp_valid after release;
//     next simultaneous request grants req0.
//  5. CNT_W=2, 5 completed ops -> op_count=1 (wrap).
//  6. req0 cmd=000 -> accepted, alu_cmd=000 in EXEC, response returned normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational alu between two requesters; accept -> EXEC next cycle -> rsp_valid the cycle after.
// Backpressure: a pending response blocks both request ports until rsp_ready; one op in flight at a time.
module alu_arbiter #(
    parameter int A_W   = 4,
    parameter int B_W   = 5,
    parameter int CMD_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [A_W-1:0]   req0_a,
    input  logic [B_W-1:0]   req0_b,
    input  logic [CMD_W-1:0] req0_cmd,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [A_W-1:0]   req1_a,
    input  logic [B_W-1:0]   req1_b,
    input  logic [CMD_W-1:0] req1_cmd,
    output logic [A_W-1:0]   alu_a,
    output logic [B_W-1:0]   alu_b,
    output logic [CMD_W-1:0] alu_cmd,
    input  logic [B_W-1:0]   alu_res,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [B_W-1:0]   rsp_res,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   prio;
    logic   grant0;
    logic   grant1;

    // Ready is held low during reset so every output reads 0 while rst is high.
    assign grant0 = (state == IDLE) && !rst && req0_valid && (!req1_valid || !prio);
    assign grant1 = (state == IDLE) && !rst && req1_valid && (!req0_valid || prio);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cmd   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_res   <= '0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_a   <= grant1 ? req1_a   : req0_a;
                        alu_b   <= grant1 ? req1_b   : req0_b;
                        alu_cmd <= grant1 ? req1_cmd : req0_cmd;
                        rsp_id  <= grant1;
                        prio    <= ~grant1;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // alu_cmd doubles as the latched command and is only visible for this one cycle.
                    rsp_res   <= alu_res;
                    alu_cmd   <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req1_a;
    logic [4:0] req0_b, req1_b;
    logic [2:0] req0_cmd, req1_cmd;
    logic [3:0] alu_a;
    logic [4:0] alu_b;
    logic [2:0] alu_cmd;
    logic [4:0] alu_res;
    logic       rsp_valid, rsp_id, rsp_ready, busy;
    logic [4:0] rsp_res;
    logic [7:0] op_count;

    logic       r0b, r1b, rsp_valid2, rsp_id2, busy2;
    logic [3:0] alu_a2;
    logic [4:0] alu_b2, rsp_res2, alu_res2;
    logic [2:0] alu_cmd2;
    logic [1:0] op_count2;

    int checks = 0;
    int errors = 0;

    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [4:0] b, input logic [2:0] c);
        case (c)
            3'd0:    return b;
            3'd1:    return {1'b0, a} + b;
            3'd2:    return b - {1'b0, a};
            3'd3:    return {1'b0, a} ^ b;
            3'd4:    return {1'b0, a} & b;
            3'd5:    return {1'b0, a} | b;
            default: return ~b;
        endcase
    endfunction

    assign alu_res  = alu_fn(alu_a, alu_b, alu_cmd);
    assign alu_res2 = alu_fn(alu_a2, alu_b2, alu_cmd2);

    alu_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_ready(rsp_ready),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0b), .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(r1b), .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_cmd(alu_cmd2), .alu_res(alu_res2),
        .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_res(rsp_res2), .rsp_ready(rsp_ready),
        .busy(busy2), .op_count(op_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one pending operation record plus the number of cycles since it was accepted.
    int         m_age = -1;
    logic       m_prio = 1'b0;
    logic [3:0] m_a = '0;
    logic [4:0] m_b = '0;
    logic [2:0] m_cmd = '0;
    logic       m_id = 1'b0;
    logic [4:0] m_res = '0;
    logic [7:0] m_cnt = '0;
    logic       e0, e1, e_valid, e_busy;
    logic [2:0] e_cmd;

    always @(negedge clk) begin
        if (rst) begin
            m_age = -1; m_prio = 1'b0; m_a = '0; m_b = '0; m_cmd = '0;
            m_id = 1'b0; m_res = '0; m_cnt = '0;
        end
        e0      = !rst && (m_age < 0) && req0_valid && (!req1_valid || !m_prio);
        e1      = !rst && (m_age < 0) && req1_valid && (!req0_valid || m_prio);
        e_cmd   = (m_age == 1) ? m_cmd : 3'd0;
        e_valid = (m_age >= 2);
        e_busy  = (m_age >= 0);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_cmd", 32'(alu_cmd), 32'(e_cmd));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_res", 32'(rsp_res), 32'(m_res));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        chk("dut2_outputs",
            32'({r0b, r1b, alu_a2, alu_b2, alu_cmd2, rsp_valid2, rsp_id2, rsp_res2, busy2, op_count2}),
            32'({e0, e1, m_a, m_b, e_cmd, e_valid, m_id, m_res, e_busy, m_cnt[1:0]}));
        if (!rst) begin
            if (m_age < 0) begin
                if (e0 || e1) begin
                    m_id   = e1;
                    m_a    = e1 ? req1_a : req0_a;
                    m_b    = e1 ? req1_b : req0_b;
                    m_cmd  = e1 ? req1_cmd : req0_cmd;
                    m_prio = !e1;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_res = alu_fn(m_a, m_b, m_cmd);
                m_age = 2;
            end else if (rsp_ready) begin
                m_cnt = m_cnt + 8'd1;
                m_age = -1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input bit p, input logic [3:0] a, input logic [4:0] b, input logic [2:0] c);
        int n;
        if (p) begin req1_a = a; req1_b = b; req1_cmd = c; req1_valid = 1'b1; end
        else   begin req0_a = a; req0_b = b; req0_cmd = c; req0_valid = 1'b1; end
        n = 0;
        @(negedge clk);
        while (!(p ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(p ? req1_ready : req0_ready), 32'd1);
        @(posedge clk);
        #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic ids[$];
    int   n;

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cmd = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cmd = '0;
        @(negedge clk);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single req0 op, a+b
        rsp_ready = 1'b1;
        req0_a = 4'd10; req0_b = 5'd1; req0_cmd = 3'b001; req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_exec_cmd", 32'(alu_cmd), 32'd1);
        chk("t1_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_cmd_cleared", 32'(alu_cmd), 32'd0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        chk("t1_rsp_res", 32'(rsp_res), 32'd11);
        @(negedge clk);
        chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // 3: req1 xor with a stalled consumer
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send(1'b1, 4'd11, 5'd21, 3'b011);
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t3_rsp_res", 32'(rsp_res), 32'd30);
            chk("t3_rsp_id", 32'(rsp_id), 32'd1);
            chk("t3_ready_blocked", 32'({req0_ready, req1_ready}), 32'd0);
            chk("t3_op_count", 32'(op_count), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_op_count_after", 32'(op_count), 32'd2);
        chk("t3_rsp_done", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // 2: both requesters continuously valid after reset
        do_reset();
        req0_a = 4'd3; req0_b = 5'd4; req0_cmd = 3'd1;
        req1_a = 4'd7; req1_b = 5'd2; req1_cmd = 3'd2;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (ids.size() < 4 && n < 60) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) ids.push_back(rsp_id);
            n++;
        end
        chk("t2_count", 32'(ids.size()), 32'd4);
        for (int i = 0; i < 4 && i < ids.size(); i++)
            chk("t2_rsp_id_seq", 32'(ids[i]), 32'(i % 2));
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // 4: reset while an op is in EXEC
        do_reset();
        send(1'b0, 4'd9, 5'd3, 3'd1);
        rst = 1'b1;
        #1;
        chk("t4_busy_zero", 32'(busy), 32'd0);
        chk("t4_cmd_zero", 32'(alu_cmd), 32'd0);
        chk("t4_alu_a_zero", 32'(alu_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1 req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("t4_grant", 32'({req0_ready, req1_ready}), 32'b10);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // 6: command 0 passes through untouched
        send(1'b0, 4'd5, 5'd7, 3'd0);
        @(negedge clk);
        chk("t6_exec_cmd", 32'(alu_cmd), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t6_rsp_res", 32'(rsp_res), 32'd7);
        wait_idle();

        // 5: five ops wrap the 2-bit counter to 1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 4'(i), 5'(i + 1), 3'd1);
            wait_idle();
        end
        chk("t5_op_count8", 32'(op_count), 32'd5);
        chk("t5_op_count2_wrap", 32'(op_count2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
